// File: rtl/qc_ldpc_pkg.sv
// Shared types for the QC-LDPC layer scheduler: shift-table entry, FSM states, width helper.
package qc_ldpc_pkg;

    // Width of an index over n items, never narrower than one bit.
    function automatic int qc_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int QC_MAXZ   = 81;
    localparam int QC_LEVELS = $clog2(QC_MAXZ);

    typedef struct packed {
        logic                 is_null;
        logic [QC_LEVELS-1:0] shift;
    } tbl_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } sched_state_t;

endpackage

// File: rtl/qc_shift_skew_line.sv
// Issue-record delay line: per-level skewed shift bits for the rotate pipeline and
// column/valid/last tags aligned with the shifter output.
module qc_shift_skew_line #(
    parameter int MEM_LAT = 1,
    parameter int LEVELS  = 7,
    parameter int COL_W   = 5
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [COL_W-1:0]  in_col,
    input  logic [LEVELS-1:0] in_shift,
    input  logic              in_last,
    output logic [LEVELS-1:0] sh_shift_val,
    output logic              out_valid,
    output logic [COL_W-1:0]  out_col,
    output logic              out_last
);

    localparam int DEPTH = MEM_LAT + LEVELS;

    // Stage i holds the record issued i cycles ago.
    logic              vld_p   [1:DEPTH];
    logic [COL_W-1:0]  col_p   [1:DEPTH];
    logic [LEVELS-1:0] shift_p [1:DEPTH];
    logic              last_p  [1:DEPTH];

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int i = 1; i <= DEPTH; i++) begin
                vld_p[i]   <= 1'b0;
                col_p[i]   <= '0;
                shift_p[i] <= '0;
                last_p[i]  <= 1'b0;
            end
        end else begin
            vld_p[1]   <= in_vld;
            col_p[1]   <= in_col;
            shift_p[1] <= in_shift;
            last_p[1]  <= in_last;
            for (int i = 2; i <= DEPTH; i++) begin
                vld_p[i]   <= vld_p[i-1];
                col_p[i]   <= col_p[i-1];
                shift_p[i] <= shift_p[i-1];
                last_p[i]  <= last_p[i-1];
            end
        end
    end

    // Level k holds data whose read was issued MEM_LAT+k cycles ago.
    always_comb begin
        sh_shift_val = '0;
        for (int k = 0; k < LEVELS; k++) begin
            sh_shift_val[k] = vld_p[MEM_LAT+k] & shift_p[MEM_LAT+k][k];
        end
    end

    assign out_valid = vld_p[DEPTH];
    assign out_col   = col_p[DEPTH];
    assign out_last  = last_p[DEPTH];

endmodule

// File: rtl/qc_shift_scheduler.sv
// Walks one QC-LDPC base-matrix row, issues message reads and drives the skewed shifter
// controls. Optional QC_SHIFT_SCHED_PERF_EN adds per-layer block and cycle counters.
module qc_shift_scheduler
    import qc_ldpc_pkg::*;
#(
    parameter int MAXZ     = QC_MAXZ,
    parameter int NUM_ROWS = 12,
    parameter int NUM_COLS = 24,
    parameter int MEM_LAT  = 1,
    parameter int LEVELS   = QC_LEVELS,
    localparam int ROW_W   = qc_clog2(NUM_ROWS),
    localparam int COL_W   = qc_clog2(NUM_COLS)
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ROW_W-1:0]  cfg_row,
    input  logic [COL_W-1:0]  cfg_col,
    input  logic              cfg_null,
    input  logic [LEVELS-1:0] cfg_shift,
    input  logic              start,
    input  logic [ROW_W-1:0]  start_row,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [COL_W-1:0]  mem_rd_addr,
    output logic [LEVELS-1:0] sh_shift_val,
    output logic              out_valid,
    output logic [COL_W-1:0]  out_col,
    output logic              out_last
`ifdef QC_SHIFT_SCHED_PERF_EN
    ,
    output logic [7:0]        perf_blocks,
    output logic [15:0]       perf_cycles
`endif
);

    localparam int DRAIN_LEN_I = MEM_LAT + LEVELS;
    localparam int CNT_W       = qc_clog2(DRAIN_LEN_I + 1);
    localparam logic [CNT_W-1:0]  DRAIN_LEN = CNT_W'(DRAIN_LEN_I);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLS - 1);
    localparam logic [LEVELS:0]   MAXZ_L    = (LEVELS + 1)'(MAXZ);

    tbl_entry_t   tbl [NUM_ROWS][NUM_COLS];
    tbl_entry_t   wr_entry;
    tbl_entry_t   cur_ent;

    sched_state_t state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d, cur_row;
    logic [COL_W-1:0]  col_q, col_d, cur_col;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              issue, later_nonnull;

    logic              vld_p0, vld_d;
    logic [COL_W-1:0]  col_p0, colp0_d;
    logic [LEVELS-1:0] shift_p0, shift_d;
    logic              last_p0, last_d;

    // Out-of-range shifts cannot address a rotation, so they fold into null.
    always_comb begin
        wr_entry.is_null = cfg_null | ({1'b0, cfg_shift} >= MAXZ_L);
        wr_entry.shift   = cfg_shift;
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    tbl[r][c] <= '{is_null: 1'b1, shift: '0};
                end
            end
        end else if (cfg_we && state_q == S_IDLE &&
                     int'(cfg_row) < NUM_ROWS && int'(cfg_col) < NUM_COLS) begin
            tbl[cfg_row][cfg_col] <= wr_entry;
        end
    end

    // Column 0 is issued on the accepting edge, so IDLE looks at start_row directly.
    always_comb begin
        cur_row       = (state_q == S_IDLE) ? start_row : row_q;
        cur_col       = (state_q == S_IDLE) ? '0 : col_q;
        cur_ent       = tbl[cur_row][cur_col];
        later_nonnull = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (c > int'(cur_col) && !tbl[cur_row][c].is_null) later_nonnull = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    state_d = S_ISSUE;
                    row_d   = start_row;
                    col_d   = COL_W'(1);
                    busy_d  = 1'b1;
                    issue   = 1'b1;
                end
            end
            S_ISSUE: begin
                issue = 1'b1;
                if (col_q == LAST_COL) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LEN) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        vld_d   = issue & ~cur_ent.is_null;
        colp0_d = vld_d ? cur_col : '0;
        shift_d = vld_d ? cur_ent.shift : '0;
        last_d  = vld_d & ~later_nonnull;
    end

    // Stage p0: issue register driving the memory read port.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            row_q    <= '0;
            col_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            vld_p0   <= 1'b0;
            col_p0   <= '0;
            shift_p0 <= '0;
            last_p0  <= 1'b0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            vld_p0   <= vld_d;
            col_p0   <= colp0_d;
            shift_p0 <= shift_d;
            last_p0  <= last_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = vld_p0;
    assign mem_rd_addr = col_p0;

    qc_shift_skew_line #(
        .MEM_LAT (MEM_LAT),
        .LEVELS  (LEVELS),
        .COL_W   (COL_W)
    ) u_skew (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .in_vld       (vld_p0),
        .in_col       (col_p0),
        .in_shift     (shift_p0),
        .in_last      (last_p0),
        .sh_shift_val (sh_shift_val),
        .out_valid    (out_valid),
        .out_col      (out_col),
        .out_last     (out_last)
    );

`ifdef QC_SHIFT_SCHED_PERF_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [7:0]  blk_cnt_q;
    logic [15:0] cyc_cnt_q;

    // Cycle count starts at 2: the start cycle plus the first busy cycle.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            blk_cnt_q   <= '0;
            cyc_cnt_q   <= '0;
            perf_blocks <= '0;
            perf_cycles <= '0;
        end else begin
            if (state_q == S_IDLE && state_d == S_ISSUE) begin
                blk_cnt_q <= {7'd0, vld_d};
                cyc_cnt_q <= 16'd2;
            end else if (state_q != S_IDLE) begin
                blk_cnt_q <= vld_d ? sat_inc8(blk_cnt_q) : blk_cnt_q;
                cyc_cnt_q <= sat_inc16(cyc_cnt_q);
            end
            if (done_d) begin
                perf_blocks <= blk_cnt_q;
                perf_cycles <= sat_inc16(cyc_cnt_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_qc_shift_scheduler.sv
// Directed bench for qc_shift_scheduler: table-driven layer model plus per-cycle compare.
module tb_qc_shift_scheduler;

    localparam int MAXZ = 81;
    localparam int NR   = 12;
    localparam int NCOL = 24;
    localparam int ML   = 1;
    localparam int LV   = 7;
    localparam int NC   = 1024;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [3:0] cfg_row;
    logic [4:0] cfg_col;
    logic       cfg_null;
    logic [6:0] cfg_shift;
    logic       start;
    logic [3:0] start_row;
    logic       busy, done, mem_rd_en, out_valid, out_last;
    logic [4:0] mem_rd_addr, out_col;
    logic [6:0] sh_shift_val;

    qc_shift_scheduler dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_row      (cfg_row),
        .cfg_col      (cfg_col),
        .cfg_null     (cfg_null),
        .cfg_shift    (cfg_shift),
        .start        (start),
        .start_row    (start_row),
        .busy         (busy),
        .done         (done),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .sh_shift_val (sh_shift_val),
        .out_valid    (out_valid),
        .out_col      (out_col),
        .out_last     (out_last)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference table and per-cycle expectations
    bit         m_null  [NR][NCOL];
    int         m_shift [NR][NCOL];
    bit         e_busy [NC];
    bit         e_done [NC];
    bit         e_rd   [NC];
    int         e_addr [NC];
    logic [6:0] e_sh   [NC];
    bit         e_ov   [NC];
    int         e_col  [NC];
    bit         e_last [NC];
    logic [6:0] sh_hist [NC];

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;
    int ov_seen   = 0;
    bit chk_en = 0;
    int T, T2, d0, o0;
    logic [80:0] pat, data;

    task automatic chk(input string name, input int at, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, at, act, exp);
        end
    endtask

    function automatic logic [80:0] rotr(input logic [80:0] x, input int n);
        if (n == 0) return x;
        return (x >> n) | (x << (MAXZ - n));
    endfunction

    always @(negedge CLK) begin
        if (chk_en && cyc < NC) begin
            sh_hist[cyc] = sh_shift_val;
            if (done === 1'b1) done_seen++;
            if (out_valid === 1'b1) ov_seen++;
            chk("busy", cyc, busy, e_busy[cyc]);
            chk("done", cyc, done, e_done[cyc]);
            chk("mem_rd_en", cyc, mem_rd_en, e_rd[cyc]);
            if (e_rd[cyc]) chk("mem_rd_addr", cyc, mem_rd_addr, e_addr[cyc]);
            chk("sh_shift_val", cyc, sh_shift_val, e_sh[cyc]);
            chk("out_valid", cyc, out_valid, e_ov[cyc]);
            if (e_ov[cyc]) begin
                chk("out_col", cyc, out_col, e_col[cyc]);
                chk("out_last", cyc, out_last, e_last[cyc]);
            end
        end
    end

    // Layer accepted with start visible in cycle t: column c is read in cycle t+1+c.
    task automatic plan_layer(input int t, input int r);
        int last, ic;
        last = -1;
        for (int c = 0; c < NCOL; c++) if (!m_null[r][c]) last = c;
        for (int i = t + 1; i <= t + NCOL + ML + LV; i++) e_busy[i] = 1'b1;
        e_done[t + NCOL + ML + LV + 1] = 1'b1;
        for (int c = 0; c < NCOL; c++) begin
            if (!m_null[r][c]) begin
                ic = t + 1 + c;
                e_rd[ic]   = 1'b1;
                e_addr[ic] = c;
                for (int k = 0; k < LV; k++)
                    if (((m_shift[r][c] >> k) & 1) == 1) e_sh[ic + ML + k][k] = 1'b1;
                e_ov[ic + ML + LV]   = 1'b1;
                e_col[ic + ML + LV]  = c;
                e_last[ic + ML + LV] = (c == last);
            end
        end
    endtask

    task automatic model_abort(input int from);
        for (int i = from; i < NC; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_addr[i] = 0;
            e_sh[i] = '0; e_ov[i] = 0; e_col[i] = 0; e_last[i] = 0;
        end
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NCOL; c++) m_null[r][c] = 1'b1;
    endtask

    task automatic cfg_write(input int r, input int c, input bit nul, input int sh, input bit accepted);
        cfg_we = 1'b1; cfg_row = 4'(r); cfg_col = 5'(c); cfg_null = nul; cfg_shift = 7'(sh);
        if (accepted) begin
            m_null[r][c]  = nul || (sh >= MAXZ);
            m_shift[r][c] = sh;
        end
        @(negedge CLK);
        cfg_we = 1'b0;
    endtask

    task automatic start_layer(input int r, output int t);
        t = cyc;
        start = 1'b1; start_row = 4'(r);
        plan_layer(t, r);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, cyc, busy, 0);
        chk({tag, "_done"}, cyc, done, 0);
        chk({tag, "_rd_en"}, cyc, mem_rd_en, 0);
        chk({tag, "_rd_addr"}, cyc, mem_rd_addr, 0);
        chk({tag, "_sh"}, cyc, sh_shift_val, 0);
        chk({tag, "_ov"}, cyc, out_valid, 0);
        chk({tag, "_col"}, cyc, out_col, 0);
        chk({tag, "_last"}, cyc, out_last, 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 0; cfg_row = 0; cfg_col = 0; cfg_null = 0; cfg_shift = 0;
        start = 0; start_row = 0;
        model_abort(0);
        @(negedge CLK);
        chk_all_zero("reset");
        chk_en = 1'b1;
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);

        cfg_write(0, 2, 0, 5, 1);
        cfg_write(0, 7, 0, 80, 1);
        cfg_write(0, 10, 0, 81, 1);
        cfg_write(0, 12, 1, 3, 1);
        cfg_write(6, 1, 0, 2, 1);
        cfg_write(6, 23, 0, 0, 1);
        for (int c = 0; c < NCOL; c++) cfg_write(5, c, 0, 1, 1);

        // Row 0: two sparse entries, shift 5 and 80
        start_layer(0, T);
        chk("pin_rd_c2", T + 3, e_rd[T+3], 1);
        chk("pin_addr_c2", T + 3, e_addr[T+3], 2);
        chk("pin_rd_c7", T + 8, e_rd[T+8], 1);
        chk("pin_ov_c2", T + 11, e_ov[T+11], 1);
        chk("pin_col_c2", T + 11, e_col[T+11], 2);
        chk("pin_last_c2", T + 11, e_last[T+11], 0);
        chk("pin_ov_c7", T + 16, e_ov[T+16], 1);
        chk("pin_last_c7", T + 16, e_last[T+16], 1);
        chk("pin_done", T + 33, e_done[T+33], 1);
        chk("pin_sh0", T + 4, e_sh[T+4][0], 1);
        chk("pin_sh1", T + 5, e_sh[T+5][1], 0);
        chk("pin_sh2", T + 6, e_sh[T+6][2], 1);
        idle(40);
        chk("skew_l0", T + 4, sh_hist[T+4][0], 1);
        chk("skew_l1", T + 5, sh_hist[T+5][1], 0);
        chk("skew_l2", T + 6, sh_hist[T+6][2], 1);
        pat  = {17'h1A5C3, 32'hDEADBEEF, 32'h0F1E2D3C};
        data = pat;
        for (int k = 0; k < LV; k++)
            if (sh_hist[T+4+k][k] === 1'b1) data = rotr(data, 1 << k);
        chk("shifter_rot5", T + 10, (data === rotr(pat, 5)), 1);

        // All-null row 3
        d0 = done_seen; o0 = ov_seen;
        start_layer(3, T);
        idle(40);
        chk("null_done_cnt", cyc, done_seen - d0, 1);
        chk("null_ov_cnt", cyc, ov_seen - o0, 0);

        // Row 5 full; start and table write while busy, start in the done cycle
        d0 = done_seen; o0 = ov_seen;
        start_layer(5, T);
        idle(4);
        start = 1'b1; start_row = 4'd3;
        @(negedge CLK);
        start = 1'b0;
        cfg_write(6, 4, 0, 3, 0);
        idle(T + 33 - cyc);
        start = 1'b1; start_row = 4'd3;
        @(negedge CLK);
        start = 1'b0;
        chk("row5_ov_cnt", cyc, ov_seen - o0, 24);
        chk("row5_done_cnt", cyc, done_seen - d0, 1);
        idle(3);
        o0 = ov_seen;
        start_layer(6, T2);
        idle(40);
        chk("row6_ov_cnt", cyc, ov_seen - o0, 2);

        // Reset mid-ISSUE aborts the layer and nulls the table
        start_layer(0, T);
        cfg_write(0, 4, 0, 3, 0);
        idle(T + 5 - cyc);
        rst_n = 1'b0;
        model_abort(T + 6);
        d0 = done_seen;
        @(negedge CLK);
        chk_all_zero("abort");
        rst_n = 1'b1;
        idle(40);
        chk("abort_no_done", cyc, done_seen - d0, 0);
        d0 = done_seen; o0 = ov_seen;
        start_layer(0, T);
        idle(40);
        chk("post_rst_done", cyc, done_seen - d0, 1);
        chk("post_rst_ov", cyc, ov_seen - o0, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
